// File: rtl/print_line_sequencer.sv
// print_line_sequencer: job-level controller for the thermal print path.
// For every line of a job it reads one 64-bit dot word, streams it LSB first
// into the print serializer, waits for the head load, fires the heat strobe
// and then advances the paper with stepper pulses.
module print_line_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int BIT_HALF       = 260,
    parameter int DRAIN_CYCLES   = 97536,
    parameter int STROBE_CYCLES  = 50000,
    parameter int STEP_HALF      = 5000,
    parameter int STEPS_PER_LINE = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_lines,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_data,
    output logic              ser_di,
    output logic              enviando,
    output logic              strobe,
    output logic              motor_step,
    output logic [ADDR_W-1:0] line_cnt
);

    localparam int TMR_W = 24;
    localparam int PH_W  = 16;

    localparam logic [TMR_W-1:0] BIT_LAST    = TMR_W'(BIT_HALF - 1);
    localparam logic [TMR_W-1:0] DRAIN_LAST  = TMR_W'(DRAIN_CYCLES - 1);
    localparam logic [TMR_W-1:0] STROBE_LAST = TMR_W'(STROBE_CYCLES - 1);
    localparam logic [TMR_W-1:0] STEP_LAST   = TMR_W'(STEP_HALF - 1);
    localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(2 * STEPS_PER_LINE - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT_RD, S_LOAD, S_BIT_HI, S_BIT_LO,
        S_DRAIN, S_STROBE, S_STEP, S_NEXT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [5:0]        bit_idx_q, bit_idx_d;
    logic [PH_W-1:0]   step_ph_q, step_ph_d;
    logic [ADDR_W-1:0] line_cnt_q, line_cnt_d;
    logic [ADDR_W-1:0] nl_q, nl_d;
    logic [63:0]       word_q, word_d;
    logic [ADDR_W-1:0] line_nxt;

    assign line_nxt = line_cnt_q + ADDR_W'(1);

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            step_ph_q  <= '0;
            line_cnt_q <= '0;
            nl_q       <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            step_ph_q  <= step_ph_d;
            line_cnt_q <= line_cnt_d;
            nl_q       <= nl_d;
            word_q     <= word_d;
        end
    end

    // Next-state and counter update; every timed state leaves with timer cleared
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        step_ph_d  = step_ph_q;
        line_cnt_d = line_cnt_q;
        nl_d       = nl_q;
        word_d     = word_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_lines != '0) begin
                        nl_d       = num_lines;
                        line_cnt_d = '0;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH:   state_d = S_WAIT_RD;
            S_WAIT_RD: state_d = S_LOAD;
            S_LOAD: begin
                word_d    = mem_data;
                bit_idx_d = '0;
                timer_d   = '0;
                state_d   = S_BIT_HI;
            end
            S_BIT_HI: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    state_d = S_BIT_LO;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_BIT_LO: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (bit_idx_q == 6'd63) begin
                        state_d = S_DRAIN;
                    end else begin
                        bit_idx_d = bit_idx_q + 6'd1;
                        state_d   = S_BIT_HI;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DRAIN: begin
                if (timer_q == DRAIN_LAST) begin
                    timer_d = '0;
                    state_d = S_STROBE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_STROBE: begin
                if (timer_q == STROBE_LAST) begin
                    timer_d   = '0;
                    step_ph_d = '0;
                    state_d   = S_STEP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_STEP: begin
                // step_ph counts half-periods: even = pulse high, odd = pulse low
                if (timer_q == STEP_LAST) begin
                    timer_d = '0;
                    if (step_ph_q == PH_LAST) begin
                        state_d = S_NEXT;
                    end else begin
                        step_ph_d = step_ph_q + PH_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_NEXT: begin
                line_cnt_d = line_nxt;
                state_d    = (line_nxt == nl_q) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state, so reset drops them at once
    always_comb begin
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        done       = (state_q == S_DONE);
        mem_rd     = (state_q == S_FETCH);
        mem_addr   = line_cnt_q;
        ser_di     = ((state_q == S_BIT_HI) || (state_q == S_BIT_LO)) ? word_q[bit_idx_q] : 1'b0;
        enviando   = (state_q == S_BIT_HI);
        strobe     = (state_q == S_STROBE);
        motor_step = (state_q == S_STEP) && !step_ph_q[0];
        line_cnt   = line_cnt_q;
    end

endmodule
